// File: rtl/mem_master.sv
// mem_master: load/store initiator for the single-port RAM tri-state bus; MEMMASTER_TURNAROUND_EN adds a turnaround cycle on read/write direction change.
package InstructionStruct;
    parameter int DWIDTH = 16;
    parameter int AWIDTH = 8;
endpackage

module mem_master #(
    parameter int DWIDTH = InstructionStruct::DWIDTH,
    parameter int AWIDTH = InstructionStruct::AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rdEn,
    output logic              mem_wrEn
);
    typedef enum logic [2:0] {IDLE, TURN, RD, WR, RSP} state_t;
    state_t r_state, w_next;
    logic r_we;
    logic [AWIDTH-1:0] r_addr, r_mem_addr;
    logic [DWIDTH-1:0] r_wdata, r_rdata;
    logic w_turn, w_drive;
`ifdef MEMMASTER_TURNAROUND_EN
    logic r_last_dir;
    assign w_turn = req_we != r_last_dir;
`else
    assign w_turn = 1'b0;
`endif
    assign mem_data  = w_drive ? r_wdata : 'z;
    assign rsp_rdata = r_rdata;
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = !req_valid ? IDLE : w_turn ? TURN : req_we ? WR : RD;
            TURN:    w_next = r_we ? WR : RD;
            RD:      w_next = RSP;
            WR:      w_next = IDLE;
            RSP:     w_next = rsp_ready ? IDLE : RSP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        req_ready = r_state == IDLE;
        rsp_valid = r_state == RSP;
        mem_rdEn  = r_state == RD;
        mem_wrEn  = r_state == WR;
        w_drive   = r_state == WR;
        mem_addr  = (r_state == RD || r_state == WR) ? r_addr : r_mem_addr;
    end
    // r_mem_addr keeps the last bus address so mem_addr is stable between accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
`ifdef MEMMASTER_TURNAROUND_EN
            r_last_dir <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == RD || r_state == WR) r_mem_addr <= r_addr;
            if (r_state == RD) r_rdata <= mem_data;
`ifdef MEMMASTER_TURNAROUND_EN
            if (r_state == RD) r_last_dir <= 1'b0;
            if (r_state == WR) r_last_dir <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed load/store sequences against a phase-level model of mem_master with a behavioural RAM.
module tb_mem_master;
    localparam bit TURN_EN =
`ifdef MEMMASTER_TURNAROUND_EN
        1'b1;
`else
        1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, mem_rdEn, mem_wrEn;
    logic [7:0]  req_addr, mem_addr;
    logic [15:0] req_wdata, rsp_rdata, d;
    wire  [15:0] mem_data;
    logic [15:0] ram [256];
    logic        ram_init;
    logic [15:0] m_mem [256];
    logic [7:0]  m_addr;
    logic        m_last;
    logic [15:0] m_rdata;
    logic        e_en, e_ready, e_rv, e_rd, e_wr;
    logic [7:0]  e_addr;
    logic [15:0] e_bus;
    logic        rdy_hist [$];
    int          checks, errors;

    always #5 clk = ~clk;

    mem_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .mem_data(mem_data), .mem_addr(mem_addr), .mem_rdEn(mem_rdEn),
        .mem_wrEn(mem_wrEn)
    );

    // The RAM drives the bus only while reading; an undriven bus floats to all ones.
    pullup (mem_data);
    assign mem_data = mem_rdEn ? ram[mem_addr] : 'z;
    always @(posedge clk) begin
        if (ram_init) for (int i = 0; i < 256; i++) ram[i] <= 16'h1000 + 16'(i * 3);
        else if (mem_wrEn) ram[mem_addr] <= mem_data;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic rdy, rv, rd, wr, input logic [7:0] a, input logic [15:0] bus);
        e_ready = rdy; e_rv = rv; e_rd = rd; e_wr = wr; e_addr = a; e_bus = bus;
    endtask

    task automatic exp_idle();
        set_exp(1, 0, 0, 0, m_addr, 16'hFFFF);
    endtask

    task automatic exp_quiet(input logic rv);
        set_exp(0, rv, 0, 0, m_addr, 16'hFFFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic after_reset();
        rst = 0;
        m_addr = 0; m_last = 0; m_rdata = 0;
        exp_idle();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_strobes", {mem_rdEn, mem_wrEn}, 0);
    endtask

    task automatic store(input logic [7:0] a, input logic [15:0] v);
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = v;
        exp_idle();
        step();
        req_valid = 0; req_addr = ~a; req_wdata = ~v;
        if (TURN_EN && !m_last) begin exp_quiet(0); step(); end
        set_exp(0, 0, 0, 1, a, v);
        step();
        m_mem[a] = v; m_addr = a; m_last = 1;
        exp_idle();
    endtask

    task automatic load(input logic [7:0] a, input int hold, input int abort, output logic [15:0] r);
        req_valid = 1; req_we = 0; req_addr = a;
        exp_idle();
        step();
        req_valid = 0; req_addr = ~a;
        r = '0;
        if (TURN_EN && m_last) begin exp_quiet(0); step(); end
        set_exp(0, 0, 1, 0, a, m_mem[a]);
        if (abort == 1) begin rst = 1; step(); after_reset(); return; end
        step();
        m_rdata = m_mem[a]; m_addr = a; m_last = 0;
        r = rsp_rdata;
        exp_quiet(1);
        if (abort == 2) begin rst = 1; step(); after_reset(); return; end
        rsp_ready = 0;
        repeat (hold) step();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        exp_idle();
    endtask

    always @(negedge clk) begin
        chk("no_overlap", {31'b0, mem_rdEn & mem_wrEn}, 0);
        if (mem_rdEn) chk("rd_bus_owner", mem_data, ram[mem_addr]);
        if (e_en) begin
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("mem_rdEn", mem_rdEn, e_rd);
            chk("mem_wrEn", mem_wrEn, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data", mem_data, e_bus);
            if (e_rv) chk("rsp_rdata", rsp_rdata, m_rdata);
            rdy_hist.push_back(req_ready);
        end
    end

    initial begin
        checks = 0; errors = 0; e_en = 0;
        rst = 1; ram_init = 1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h1000 + 16'(i * 3);
        repeat (2) step();
        ram_init = 0;
        after_reset();
        e_en = 1;
        step();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        step();
        store(8'h05, 16'h00AB);
        load(8'h05, 0, 0, d);
        chk("store_load_05", d, 16'h00AB);
        load(8'h05, 4, 0, d);
        chk("held_rsp_05", d, 16'h00AB);
        store(8'h03, 16'h0333);
        rdy_hist.delete();
        store(8'h01, 16'h1111);
        store(8'h02, 16'h2222);
        chk("b2b_ready_count", rdy_hist.size(), 4);
        if (rdy_hist.size() >= 4)
            chk("b2b_ready_pattern", {28'b0, rdy_hist[0], rdy_hist[1], rdy_hist[2], rdy_hist[3]}, 4'b1010);
        load(8'h01, 0, 0, d);
        chk("b2b_read_01", d, 16'h1111);
        load(8'h02, 1, 0, d);
        chk("b2b_read_02", d, 16'h2222);
        load(8'h10, 0, 0, d);
        chk("init_read_10", d, 16'h1030);
        store(8'h07, 16'h7777);
        load(8'h07, 0, 1, d);
        step();
        step();
        load(8'h07, 0, 0, d);
        chk("after_rd_abort_07", d, 16'h7777);
        load(8'h02, 0, 2, d);
        chk("pre_rsp_abort_02", d, 16'h2222);
        step();
        step();
        load(8'h02, 2, 0, d);
        chk("after_rsp_abort_02", d, 16'h2222);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
